// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] MEMOP_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// Combinational 2-way round-robin picker. grant[0] = IFU, grant[1] = LSU.
// When both requesters are valid, the one that did not win last time is chosen.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    // One-hot pick; ties broken toward whoever was not served last.
    always_comb begin
        grant    = 2'b00;
        grant[0] = ifu_valid && (!lsu_valid || (last_grant == OWN_LSU));
        grant[1] = lsu_valid && (!ifu_valid || (last_grant == OWN_IFU));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and load/store.
// One transaction outstanding at a time; the response is routed to its issuer.
// Optional: define MEM_ARB_TIMEOUT_EN to bound the response wait to
// TIMEOUT_CYCLES cycles and report an error pulse to the owner on expiry.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [2:0]        lsu_memop,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_memop,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    logic [1:0] grant;

    arb_rr2 u_rr (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready only in IDLE and only to the picked requester; held low during reset.
    always_comb begin
        ifu_req_ready = (state == IDLE) && !rst && grant[0];
        lsu_req_ready = (state == IDLE) && !rst && grant[1];
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    // Without the timeout the wait is unbounded and never reports an error.
    assign ifu_rsp_err = 1'b0;
    assign lsu_rsp_err = 1'b0;
`endif

    // Arbitration FSM: accept, present to memory, wait, return response to owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            last_grant    <= OWN_LSU;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_memop     <= 3'b000;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            // Response pulses last exactly one cycle.
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ifu_req_ready) begin
                        owner         <= OWN_IFU;
                        last_grant    <= OWN_IFU;
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_memop     <= MEMOP_WORD;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (lsu_req_ready) begin
                        owner         <= OWN_LSU;
                        last_grant    <= OWN_LSU;
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_memop     <= lsu_memop;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // Memory never answers before it has accepted the request.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (owner == OWN_IFU) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= mem_rsp_data;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= mem_rsp_data;
                        end
                        state <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Give up: the owner sees an error pulse with zero data.
                        if (owner == OWN_IFU) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_err   <= 1'b1;
                            ifu_rsp_data  <= '0;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_err   <= 1'b1;
                            lsu_rsp_data  <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a hand-computed transaction table,
// randomized transactions against a transaction-level model, and hand-written
// sequences for overlap, mid-transaction reset and (optionally) timeout.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [2:0]    lsu_memop;
    logic          lsu_rsp_valid, lsu_rsp_err;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_memop;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_memop(lsu_memop),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_memop(mem_memop),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_a;
        logic [31:0] lsu_a;
        logic        lsu_w;
        logic [31:0] lsu_d;
        logic [2:0]  lsu_op;
        int          req_dly;
        int          rsp_dly;
        logic [31:0] rsp_d;
        logic        exp_lsu;
        logic [31:0] exp_a;
        logic        exp_w;
        logic [31:0] exp_d;
        logic [2:0]  exp_op;
    } txn_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input txn_t t);
        chk("mem_req_valid", mem_req_valid, 1'b1);
        chk("mem_addr", mem_addr, t.exp_a);
        chk("mem_wen", mem_wen, t.exp_w);
        chk("mem_wdata", mem_wdata, t.exp_d);
        chk("mem_memop", mem_memop, t.exp_op);
    endtask

    // Drives one complete transaction and checks every phase of it.
    task automatic run_txn(input txn_t t);
        ifu_req_valid = t.ifu_v;  lsu_req_valid = t.lsu_v;
        ifu_addr = t.ifu_a;  lsu_addr = t.lsu_a;  lsu_wen = t.lsu_w;
        lsu_wdata = t.lsu_d;  lsu_memop = t.lsu_op;
        mem_rsp_valid = 1'b1;  mem_rsp_data = $urandom;   // stray response in IDLE
        #1;
        chk("ifu_req_ready", ifu_req_ready, t.ifu_v && !t.exp_lsu);
        chk("lsu_req_ready", lsu_req_ready, t.lsu_v && t.exp_lsu);
        tick();
        ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
        ifu_addr = $urandom;  lsu_addr = $urandom;  lsu_wdata = $urandom;
        lsu_wen = 1'($urandom);  lsu_memop = 3'($urandom);
        for (int i = 0; i < t.req_dly; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'($urandom);          // ignored before acceptance
            mem_rsp_data  = $urandom;
            check_mem(t);
            chk("rsp_quiet_req", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
            tick();
            lsu_addr = $urandom;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        check_mem(t);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < t.rsp_dly; i++) begin
            chk("mem_req_drop", mem_req_valid, 1'b0);
            chk("rsp_quiet_wait", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
            tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = t.rsp_d;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        chk("ifu_rsp_valid", ifu_rsp_valid, !t.exp_lsu);
        chk("lsu_rsp_valid", lsu_rsp_valid, t.exp_lsu);
        chk("rsp_err", {ifu_rsp_err, lsu_rsp_err}, 2'b00);
        chk("rsp_data", t.exp_lsu ? lsu_rsp_data : ifu_rsp_data, t.rsp_d);
        tick();
        chk("rsp_pulse_end", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        chk("rsp_data_hold", t.exp_lsu ? lsu_rsp_data : ifu_rsp_data, t.rsp_d);
    endtask

    // Reference rules: a sole requester wins; on contention the one not served
    // last wins. IFU accesses are word reads with zero write data.
    task automatic model(inout txn_t t, inout logic last_lsu);
        if (t.ifu_v && t.lsu_v) t.exp_lsu = !last_lsu;
        else                    t.exp_lsu = t.lsu_v;
        last_lsu = t.exp_lsu;
        if (t.exp_lsu) begin
            t.exp_a = t.lsu_a;  t.exp_w = t.lsu_w;  t.exp_d = t.lsu_d;  t.exp_op = t.lsu_op;
        end else begin
            t.exp_a = t.ifu_a;  t.exp_w = 1'b0;  t.exp_d = 32'h0;  t.exp_op = 3'b010;
        end
    endtask

    txn_t tbl[7];
    txn_t rt;
    logic last_lsu;

    initial begin
        // Hand-computed expectations, starting from reset (last grant = LSU).
        tbl[0] = '{1, 1, 32'h80000000, 32'h80000080, 0, 32'h11111111, 3'b100, 0, 0, 32'h00000413,
                   0, 32'h80000000, 0, 32'h00000000, 3'b010};
        tbl[1] = '{1, 1, 32'h80000004, 32'h80000080, 0, 32'h11111111, 3'b100, 1, 2, 32'h000000AB,
                   1, 32'h80000080, 0, 32'h11111111, 3'b100};
        tbl[2] = '{1, 0, 32'h80000000, 32'h12345678, 1, 32'h55555555, 3'b000, 0, 0, 32'h00000413,
                   0, 32'h80000000, 0, 32'h00000000, 3'b010};
        tbl[3] = '{0, 1, 32'h00000000, 32'h80001000, 1, 32'hDEADBEEF, 3'b000, 4, 0, 32'h00000000,
                   1, 32'h80001000, 1, 32'hDEADBEEF, 3'b000};
        tbl[4] = '{1, 1, 32'h80000008, 32'h80003000, 1, 32'h01020304, 3'b001, 2, 1, 32'h00100093,
                   0, 32'h80000008, 0, 32'h00000000, 3'b010};
        tbl[5] = '{0, 1, 32'h80000010, 32'h80002000, 0, 32'h00000000, 3'b001, 0, 3, 32'hCAFEF00D,
                   1, 32'h80002000, 0, 32'h00000000, 3'b001};
        tbl[6] = '{1, 1, 32'h8000000C, 32'h80004000, 1, 32'hA5A5A5A5, 3'b010, 3, 0, 32'hFFFFFFFF,
                   0, 32'h8000000C, 0, 32'h00000000, 3'b010};

        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
        lsu_wen = 0; lsu_wdata = 0; lsu_memop = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        tick();
        tick();
        chk("reset_outputs", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                              ifu_rsp_err, lsu_rsp_err, mem_req_valid, mem_wen, mem_memop}, 11'h0);
        chk("reset_data", {mem_addr, mem_wdata}, 64'h0);
        chk("reset_rsp_data", {ifu_rsp_data, lsu_rsp_data}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Randomized transactions against the reference rules.
        last_lsu = 1'b0;
        for (int n = 0; n < 200; n++) begin
            rt.ifu_v = 1'($urandom);
            rt.lsu_v = rt.ifu_v ? 1'($urandom) : 1'b1;
            rt.ifu_a = $urandom;  rt.lsu_a = $urandom;  rt.lsu_w = 1'($urandom);
            rt.lsu_d = $urandom;  rt.lsu_op = 3'($urandom);
            rt.req_dly = int'($urandom_range(0, 3));
            rt.rsp_dly = int'($urandom_range(0, 3));
            rt.rsp_d = $urandom;
            model(rt, last_lsu);
            run_txn(rt);
        end

        // Overlap: a waiting fetch is accepted in the same cycle as the load pulse.
        lsu_req_valid = 1; lsu_addr = 32'h80005000; lsu_wen = 0; lsu_memop = 3'b010;
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0BADF00D;
        ifu_req_valid = 1; ifu_addr = 32'h80000020;
        tick();
        mem_rsp_valid = 0;
        chk("ovl_lsu_pulse", lsu_rsp_valid, 1'b1);
        chk("ovl_lsu_data", lsu_rsp_data, 32'h0BADF00D);
        chk("ovl_ifu_ready", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0;
        chk("ovl_mem_addr", mem_addr, 32'h80000020);
        chk("ovl_mem_memop", mem_memop, 3'b010);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h00000013;
        tick();
        mem_rsp_valid = 0;
        chk("ovl_ifu_pulse", {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
        chk("ovl_ifu_data", ifu_rsp_data, 32'h00000013);
        tick();

        // Reset while waiting for memory: the transaction vanishes.
        ifu_req_valid = 1; ifu_addr = 32'h80000040;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h77777777;
        chk("rst_outputs", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                            ifu_rsp_err, lsu_rsp_err, mem_req_valid, mem_wen, mem_memop}, 11'h0);
        chk("rst_data", {mem_addr, mem_wdata, ifu_rsp_data, lsu_rsp_data}, 128'h0);
        tick();
        mem_rsp_valid = 0;
        chk("rst_no_pulse", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        chk("rst_rr_restart", {ifu_req_ready, lsu_req_ready}, 2'b10);
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: no response for TO wait cycles produces an error pulse.
        lsu_req_valid = 1; lsu_addr = 32'h80006000; lsu_wen = 0; lsu_memop = 3'b010;
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < TO; i++) begin
            chk("to_quiet", lsu_rsp_valid, 1'b0);
            tick();
        end
        chk("to_pulse", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b110);
        chk("to_data", lsu_rsp_data, 32'h0);
        mem_rsp_valid = 1; mem_rsp_data = 32'h12121212;
        tick();
        mem_rsp_valid = 0;
        chk("to_late_ignored", {lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err}, 3'b000);
        chk("to_late_data", lsu_rsp_data, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU) once the single-cycle core is split into fetch and execute phases.
- Accepts one request at a time from either requester and drives a valid/ready memory request channel.
- Waits for the memory response and routes it back to the requester that issued it.
- Sits between the core and the memory model; one transaction outstanding at most.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, response wait limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  fetch response pulse
- ifu_rsp_data  out  DATA_W  fetched instruction
- ifu_rsp_err  out  1  fetch timed out
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_memop  in  3  access size/sign code
- lsu_rsp_valid  out  1  data response pulse (load data or store ack)
- lsu_rsp_data  out  DATA_W  load data
- lsu_rsp_err  out  1  data access timed out
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_memop  out  3  memory access code
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DATA_W  memory read data

Behaviour:
- Clocking and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - On reset: state IDLE; all outputs 0; last_grant = LSU.
  - Reset mid-transaction aborts it with no response pulse.
- States: IDLE, REQ, WAIT.
- IDLE:
  - The *_req_ready output is combinational and is asserted only for the granted requester.
  - One requester valid: that requester is granted.
  - Both valid: grant goes to the requester that is NOT last_grant (2-way round-robin).
  - On handshake (valid && ready): latch addr/wen/wdata/memop and owner, update last_grant, go to REQ.
  - IFU requests are latched with wen=0, memop=MEMOP_WORD (3'b010), wdata=0.
- REQ:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT.
  - mem_rsp_valid in REQ is ignored; memory responds no earlier than the cycle after acceptance.
- WAIT:
  - On mem_rsp_valid in cycle M: register mem_rsp_data into the owner's *_rsp_data.
  - Assert the owner's *_rsp_valid for exactly cycle M+1; state is IDLE at M+1.
  - A new request can therefore be accepted in M+1, overlapping the response pulse.
- Response rules:
  - Stores still produce lsu_rsp_valid (ack); lsu_rsp_data = mem_rsp_data as returned.
  - Non-owner rsp_valid stays 0.
  - rsp_data holds its value until the next response.
  - mem_rsp_valid in IDLE is ignored.
- Minimum latency from request accept to response pulse: 3 cycles (mem_req_ready same cycle, mem_rsp_valid next cycle).
- The latched request is unchanged by requester inputs after acceptance.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering WAIT, incremented each WAIT cycle without mem_rsp_valid.
  - When it reaches TIMEOUT_CYCLES: owner rsp_valid=1 and rsp_err=1 next cycle, rsp_data=0, state IDLE.
  - A late mem_rsp_valid is then ignored.
  - mem_rsp_valid arriving in the same cycle the count hits the limit counts as a normal response (no error).
- Undefined: no counter; WAIT is unbounded; ifu_rsp_err and lsu_rsp_err are tied 0.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE/REQ/WAIT)
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - MEMOP_WORD = 3'b010
- Sub-module arb_rr2: combinational 2-way round-robin picker.
  - Inputs: two valids, last_grant.
  - Outputs: one-hot grant.

Test Plan:
- IFU only, addr 0x80000000, mem ready immediately, rsp 0x00000413 one cycle later -> mem_memop=3'b010, mem_wen=0, ifu_rsp_valid pulse 1 cycle with data 0x00000413, lsu_rsp_valid stays 0.
- IFU and LSU valid together from reset (last_grant=LSU) -> IFU granted first; next IDLE grants LSU; mem_addr sequence IFU addr then LSU addr.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, memop 3'b000, mem_req_ready held low 4 cycles -> mem request fields stable all 5 cycles; lsu_rsp_valid ack after the response.
- Response arrives in cycle M, new IFU request waiting -> ifu_req_ready=1 in M+1 while the previous response pulse is high.
- rst asserted during WAIT, then mem_rsp_valid -> no rsp_valid pulse; all outputs 0; IDLE.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> lsu_rsp_valid=1, lsu_rsp_err=1, data 0 after 8 WAIT cycles; a later mem_rsp_valid is ignored.
